// File: rtl/gen_pkg.sv
// Shared definitions for the gen register bank and its read-back responder:
// FSM state codes, default geometry and a constant-evaluable clog2.
package gen_pkg;

  localparam int BUS_WIDTH_DEF = 15;
  localparam int NUM_REGS_DEF  = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CAPT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/gen_rd_mux.sv
// Combinational register-word select with range check; addresses at or
// above NUM_REGS yield a zero word and never index past the bus.
module gen_rd_mux import gen_pkg::*; #(
  parameter int bus_width = BUS_WIDTH_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ADDR_W    = 2
) (
  input  logic [NUM_REGS*(bus_width+1)-1:0] regs_i,
  input  logic [ADDR_W-1:0]                 addr_i,
  output logic [bus_width:0]                word_o,
  output logic                              in_range_o
);

  localparam int W = bus_width + 1;

  always_comb begin
    // NOTE: every output gets a default before the loop; without it a
    // non-matching address would leave them unassigned and infer a latch.
    word_o     = '0;
    in_range_o = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (addr_i == ADDR_W'(k)) begin
        word_o     = regs_i[k*W +: W];
        in_range_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gen_rd.sv
// Read-back responder: edge-detects the host read strobe, captures one
// register word, holds it under handshake and flags range errors/timeouts.
module gen_rd import gen_pkg::*; #(
  parameter int bus_width = BUS_WIDTH_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int ADDR_W    = 2,
  parameter int HOLD_MAX  = 255
) (
  input  logic                              sysclk,
  input  logic                              reset,
  input  logic                              rdb,
  input  logic [ADDR_W-1:0]                 addr,
  input  logic [NUM_REGS*(bus_width+1)-1:0] regs_in,
  output logic [bus_width:0]                dout,
  output logic                              dout_valid,
  output logic                              busy,
  output logic [NUM_REGS-1:0]               rd_pulse,
  output logic                              addr_err,
  output logic                              timeout
);

  localparam int W     = bus_width + 1;
  localparam int CNT_W = clog2(HOLD_MAX + 1);

  logic [1:0]          state_q, state_d;
  logic                rdb_q;
  logic                armed_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [W-1:0]        dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                busy_q, busy_d;
  logic [NUM_REGS-1:0] rd_pulse_q, rd_pulse_d;
  logic                addr_err_q, addr_err_d;
  logic                timeout_q, timeout_d;
  logic [W-1:0]        word;
  logic                in_range;
  logic                start;

  gen_rd_mux #(
    .bus_width (bus_width),
    .NUM_REGS  (NUM_REGS),
    .ADDR_W    (ADDR_W)
  ) u_mux (
    .regs_i     (regs_in),
    .addr_i     (addr_q),
    .word_o     (word),
    .in_range_o (in_range)
  );

  // armed_q only rises once rdb has really been sampled high, so a strobe
  // already low when reset is released cannot look like a falling edge.
  assign start = (state_q == IDLE) && !rdb && rdb_q && armed_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hold_cnt_d   = hold_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    rd_pulse_d   = '0;
    addr_err_d   = addr_err_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        dout_valid_d = 1'b0;
        if (start) begin
          addr_d     = addr;
          addr_err_d = 1'b0;
          timeout_d  = 1'b0;
          state_d    = CAPT;
        end
      end
      CAPT: begin
        if (in_range) begin
          dout_d     = word;
          rd_pulse_d = NUM_REGS'(1) << addr_q;
        end else begin
          dout_d     = '0;
          addr_err_d = 1'b1;
        end
        dout_valid_d = 1'b1;
        hold_cnt_d   = '0;
        state_d      = HOLD;
      end
      HOLD: begin
        if (rdb) begin
          dout_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (hold_cnt_q == CNT_W'(HOLD_MAX - 1)) begin
          timeout_d    = 1'b1;
          dout_valid_d = 1'b0;
          state_d      = IDLE;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        dout_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rdb_q        <= 1'b1;
      armed_q      <= 1'b0;
      addr_q       <= '0;
      hold_cnt_q   <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      rd_pulse_q   <= '0;
      addr_err_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q      <= state_d;
      rdb_q        <= rdb;
      armed_q      <= armed_q | rdb;
      addr_q       <= addr_d;
      hold_cnt_q   <= hold_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      rd_pulse_q   <= rd_pulse_d;
      addr_err_q   <= addr_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign rd_pulse   = rd_pulse_q;
  assign addr_err   = addr_err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_gen_rd.sv
// Bench for gen_rd: a 4-register instance (HOLD_MAX=255) and a 3-register
// instance (HOLD_MAX=4) share one stimulus and are checked against a read model.
module tb_gen_rd;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic        rdb    = 1'b1;
  logic [1:0]  addr   = 2'd0;
  logic [15:0] regs_w [4];

  logic [63:0] regs_in4;
  logic [47:0] regs_in3;
  logic [15:0] dout4, dout3;
  logic        valid4, valid3, busy4, busy3, err4, err3, to4, to3;
  logic [3:0]  pulse4;
  logic [2:0]  pulse3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          active;
    int          age;
    int          a;
    logic [15:0] dout;
    bit          valid;
    bit          err;
    bit          to;
    bit          prev_hi;
    int          pulse;
  } model_t;

  model_t m4, m3;

  assign regs_in4 = {regs_w[3], regs_w[2], regs_w[1], regs_w[0]};
  assign regs_in3 = {regs_w[2], regs_w[1], regs_w[0]};

  gen_rd #(.bus_width(15), .NUM_REGS(4), .ADDR_W(2), .HOLD_MAX(255)) u4 (
    .sysclk(sysclk), .reset(reset), .rdb(rdb), .addr(addr), .regs_in(regs_in4),
    .dout(dout4), .dout_valid(valid4), .busy(busy4), .rd_pulse(pulse4),
    .addr_err(err4), .timeout(to4)
  );

  gen_rd #(.bus_width(15), .NUM_REGS(3), .ADDR_W(2), .HOLD_MAX(4)) u3 (
    .sysclk(sysclk), .reset(reset), .rdb(rdb), .addr(addr), .regs_in(regs_in3),
    .dout(dout3), .dout_valid(valid3), .busy(busy3), .rd_pulse(pulse3),
    .addr_err(err3), .timeout(to3)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset(inout model_t s);
    s.active  = 1'b0;
    s.age     = 0;
    s.a       = 0;
    s.dout    = '0;
    s.valid   = 1'b0;
    s.err     = 1'b0;
    s.to      = 1'b0;
    s.prev_hi = 1'b0;
    s.pulse   = 0;
  endfunction

  // One clock edge of a read: age counts edges since the falling strobe was seen.
  function automatic void model_step(inout model_t s, input int nregs, input int hmax);
    s.pulse = 0;
    if (s.active) begin
      s.age++;
      if (s.age == 1) begin
        if (s.a < nregs) begin
          s.dout  = regs_w[s.a];
          s.pulse = 1 << s.a;
        end else begin
          s.dout = '0;
          s.err  = 1'b1;
        end
        s.valid = 1'b1;
      end else if (rdb) begin
        s.active = 1'b0;
        s.valid  = 1'b0;
      end else if (s.age - 1 == hmax) begin
        s.to     = 1'b1;
        s.active = 1'b0;
        s.valid  = 1'b0;
      end
    end else if (!rdb && s.prev_hi) begin
      s.active = 1'b1;
      s.age    = 0;
      s.a      = int'(addr);
      s.err    = 1'b0;
      s.to     = 1'b0;
    end
    s.prev_hi = rdb;
  endfunction

  always @(posedge sysclk) begin
    #1;
    if (!reset) begin
      model_reset(m4);
      model_reset(m3);
    end else begin
      model_step(m4, 4, 255);
      model_step(m3, 3, 4);
    end
    check("u4.dout",  32'(dout4),  32'(m4.dout));
    check("u4.valid", 32'(valid4), 32'(m4.valid));
    check("u4.busy",  32'(busy4),  32'(m4.active));
    check("u4.pulse", 32'(pulse4), 32'(m4.pulse));
    check("u4.err",   32'(err4),   32'(m4.err));
    check("u4.to",    32'(to4),    32'(m4.to));
    check("u3.dout",  32'(dout3),  32'(m3.dout));
    check("u3.valid", 32'(valid3), 32'(m3.valid));
    check("u3.busy",  32'(busy3),  32'(m3.active));
    check("u3.pulse", 32'(pulse3), 32'(m3.pulse));
    check("u3.err",   32'(err3),   32'(m3.err));
    check("u3.to",    32'(to3),    32'(m3.to));
  end

  task automatic step(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".u4_out"}, {dout4, 10'd0, valid4, busy4, pulse4, err4, to4}, 32'd0);
    check({tag, ".u3_out"}, {dout3, 11'd0, valid3, busy3, pulse3, err3, to3}, 32'd0);
  endtask

  initial begin
    regs_w[0] = 16'h1111;
    regs_w[1] = 16'h2222;
    regs_w[2] = 16'hA5A5;
    regs_w[3] = 16'h4444;
    step(3);
    check_all_zero("reset");
    reset = 1'b1;
    step(4);

    // Read register 2, strobe held low for 5 cycles.
    addr = 2'd2; rdb = 1'b0;
    step(1);
    check("rd2.busy_after_start", 32'(busy4), 32'd1);
    check("rd2.valid_after_start", 32'(valid4), 32'd0);
    step(1);
    check("rd2.dout", 32'(dout4), 32'hA5A5);
    check("rd2.valid", 32'(valid4), 32'd1);
    check("rd2.pulse4", 32'(pulse4), 32'b0100);
    check("rd2.pulse3", 32'(pulse3), 32'b100);
    check("rd2.model_dout", 32'(m4.dout), 32'hA5A5);
    step(1);
    check("rd2.pulse_gone", 32'(pulse4), 32'd0);
    step(2);
    check("rd2.valid_held", 32'(valid4), 32'd1);
    rdb = 1'b1;
    step(1);
    check("rd2.valid_drop", 32'(valid4), 32'd0);
    check("rd2.dout_kept", 32'(dout4), 32'hA5A5);
    step(2);

    // Address 3: out of range for the 3-register instance only.
    addr = 2'd3; rdb = 1'b0;
    step(2);
    check("oor.u3_dout", 32'(dout3), 32'd0);
    check("oor.u3_err", 32'(err3), 32'd1);
    check("oor.u3_pulse", 32'(pulse3), 32'd0);
    check("oor.u4_dout", 32'(dout4), 32'h4444);
    check("oor.u4_err", 32'(err4), 32'd0);
    check("oor.model_err", 32'(m3.err), 32'd1);
    rdb = 1'b1;
    step(2);
    addr = 2'd0; rdb = 1'b0;
    step(2);
    check("rd0.u3_err_clr", 32'(err3), 32'd0);
    check("rd0.u3_dout", 32'(dout3), 32'h1111);
    rdb = 1'b1;
    step(2);

    // Timeout on the HOLD_MAX=4 instance; strobe stays low 20 cycles.
    addr = 2'd1; rdb = 1'b0;
    step(5);
    check("to.valid_before", 32'(valid3), 32'd1);
    check("to.flag_before", 32'(to3), 32'd0);
    step(1);
    check("to.flag", 32'(to3), 32'd1);
    check("to.valid_drop", 32'(valid3), 32'd0);
    step(14);
    check("to.no_restart", 32'(busy3), 32'd0);
    check("to.sticky", 32'(to3), 32'd1);
    check("to.u4_still_valid", 32'(valid4), 32'd1);
    rdb = 1'b1;
    step(1);
    rdb = 1'b0;
    step(1);
    check("to.cleared", 32'(to3), 32'd0);
    check("to.new_read_busy", 32'(busy3), 32'd1);
    step(1);
    rdb = 1'b1;
    step(2);

    // One-cycle strobe: capture still happens, valid for a single cycle.
    addr = 2'd0; rdb = 1'b0;
    step(1);
    rdb = 1'b1;
    step(1);
    check("glitch.valid", 32'(valid4), 32'd1);
    check("glitch.pulse", 32'(pulse4), 32'b0001);
    step(1);
    check("glitch.valid_drop", 32'(valid4), 32'd0);
    check("glitch.pulse_gone", 32'(pulse4), 32'd0);
    step(2);

    // Data freeze: word 1 changes under a held read.
    addr = 2'd1; rdb = 1'b0;
    step(2);
    regs_w[1] = 16'hFFFF;
    addr = 2'd3;
    step(2);
    check("freeze.u4", 32'(dout4), 32'h2222);
    check("freeze.u3", 32'(dout3), 32'h2222);
    rdb = 1'b1;
    step(2);

    // Reset asserted while in CAPT.
    addr = 2'd1; rdb = 1'b0;
    step(1);
    #2 reset = 1'b0;
    #1 check_all_zero("midrst");
    step(2);
    reset = 1'b1;
    step(3);
    check("midrst.no_start4", 32'(busy4), 32'd0);
    check("midrst.no_start3", 32'(busy3), 32'd0);
    rdb = 1'b1;
    step(1);
    rdb = 1'b0;
    step(2);
    check("midrst.reread", 32'(dout4), 32'hFFFF);
    rdb = 1'b1;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gen_rd.md
Name: gen_rd

Overview:
- Read-back responder for the per-bit write register bank (wbit1 array).
- The register bank is the write side; this block answers host read strobes.
- It latches a register address, captures the selected register word from the flattened register outputs and presents it with a valid flag held under handshake.
- It also issues one-cycle read notifications, used for clear-on-read, and detects stuck read strobes with a timeout counter.

Parameters:
- bus_width, 15: MSB index of a register word; word width is bus_width+1.
- NUM_REGS, 4: number of readable registers.
- ADDR_W, 2: address width; 2**ADDR_W may exceed NUM_REGS.
- HOLD_MAX, 255: maximum cycles in HOLD with rdb low before timeout; must be ≥1.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rdb  in  1  active-low read strobe; synchronous to sysclk; level-held by host.
- addr  in  ADDR_W  register address; sampled only at read start.
- regs_in  in  NUM_REGS*(bus_width+1)  register words; register k occupies bits [k*(bus_width+1) +: bus_width+1].
- dout  out  bus_width+1  read data.
- dout_valid  out  1  dout holds data for the current read.
- busy  out  1  high in CAPT and HOLD.
- rd_pulse  out  NUM_REGS  one-hot, one-cycle notification that register k was read.
- addr_err  out  1  sticky; last read addressed a register ≥ NUM_REGS.
- timeout  out  1  sticky; last read timed out in HOLD.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; rdb_q=1; addr_q=0; hold_cnt=0.
  - dout=0, dout_valid=0, busy=0, rd_pulse=0, addr_err=0, timeout=0.
  - Reset mid-read aborts the read immediately; no rd_pulse is emitted.
- Edge detect:
  - rdb_q is rdb registered.
  - start = (state==IDLE) && rdb==0 && rdb_q==1.
  - A strobe already low when leaving reset or returning to IDLE is not a start; it needs a fresh high-to-low transition.
- IDLE:
  - On start: addr_q<=addr, addr_err<=0, timeout<=0, go to CAPT.
  - dout keeps its last value; dout_valid=0.
- CAPT (exactly 1 cycle):
  - If addr_q<NUM_REGS: dout<=word[addr_q]; rd_pulse[addr_q]<=1 for one cycle.
  - Else: dout<=0; addr_err<=1; rd_pulse stays 0.
  - In both cases dout_valid<=1, hold_cnt<=0, go to HOLD.
- HOLD:
  - dout is frozen; later changes on regs_in or addr are ignored.
  - If rdb==1: dout_valid<=0, go to IDLE.
  - Else if hold_cnt==HOLD_MAX-1: timeout<=1, dout_valid<=0, go to IDLE.
  - Else hold_cnt<=hold_cnt+1 (saturating width clog2(HOLD_MAX+1)).
- Latency: start sampled at edge N → dout and dout_valid valid after edge N+1; rd_pulse high during cycle N+1..N+2.
- Simultaneous and boundary cases:
  - rdb rises during CAPT: HOLD is still entered; it exits on the next edge, so dout_valid is high exactly 1 cycle.
  - Glitch of rdb low for one cycle: still a full read (start, CAPT, HOLD), exit at first high sample.
  - addr = NUM_REGS..2**ADDR_W-1: error path only; never index regs_in out of range.
  - NUM_REGS==2**ADDR_W: addr_err is never set.
- busy = (state!=IDLE), registered.

Decomposition:
- Shared package gen_pkg holds:
  - state encoding: IDLE=2'd0, CAPT=2'd1, HOLD=2'd2;
  - a clog2 function;
  - default bus_width/NUM_REGS constants shared with gen.
- Natural sub-module: gen_rd_mux. Combinational word select from regs_in by addr_q, with range check producing word and in_range. The FSM, counter and edge detect stay in gen_rd.

Test Plan:
- Read register 2: regs_in words {0x1111,0x2222,0xA5A5,0x4444}, addr=2, rdb 1→0 at edge 10, held 5 cycles.
  - dout=0xA5A5 and dout_valid=1 from edge 11.
  - rd_pulse=4'b0100 for exactly one cycle.
  - dout_valid=0 one edge after rdb returns high.
- Out-of-range read: NUM_REGS=3, ADDR_W=2, addr=3.
  - dout=0, addr_err=1, rd_pulse=0.
  - A following valid read to addr 0 clears addr_err and returns 0x1111.
- Timeout: HOLD_MAX=4, rdb held low 20 cycles.
  - timeout=1 and dout_valid=0 after 4 HOLD cycles.
  - No second read while rdb stays low; a new 1→0 edge starts a read and clears timeout.
- One-cycle strobe: rdb low for 1 cycle.
  - dout_valid high exactly 1 cycle; exactly one rd_pulse.
- Data freeze: change regs_in word 1 from 0x2222 to 0xFFFF during HOLD of a read to addr 1.
  - dout stays 0x2222.
- Reset mid-read: assert reset in CAPT.
  - All outputs 0 immediately (async).
  - After release with rdb still low, no read starts until rdb goes high then low.
